// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// data_mem_responder : byte-enabled word memory answering a req/gnt/rvalid bus.
// Optional macro DATA_MEM_STALL_EN gates grant with an LFSR stall pattern.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          GNT_WAIT    = 0,
    parameter int          RVALID_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    logic [31:0]           mem_q [DEPTH_WORDS];
    logic [3:0]            wait_cnt_q;
    logic [3:0]            wait_cnt_d;
    logic                  stall_ok;
    logic                  accept;
    logic                  in_range;
    logic [31:0]           idx;
    logic [IDX_W-1:0]      idx_t;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [RVALID_LAT-1:0] vld_q;
    logic [RVALID_LAT-1:0] err_q;
    logic [31:0]           rdata_q [RVALID_LAT];

`ifdef DATA_MEM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign stall_ok = lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    assign data_gnt_o = data_req_i && (wait_cnt_q == 4'(GNT_WAIT)) && rst_ni && stall_ok;
    assign accept     = data_req_i && data_gnt_o;

    assign idx      = (data_addr_i - BASE_ADDR) >> 2;
    assign in_range = (data_addr_i >= BASE_ADDR) && (idx < 32'(DEPTH_WORDS));
    assign idx_t    = idx[IDX_W-1:0];

    // Counter saturates at the grant threshold so a stalled grant stays pending
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!data_req_i || accept) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'(GNT_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        if (accept) begin
            if (!in_range) begin
                resp_err   = 1'b1;
                resp_rdata = data_we_i ? 32'd0 : OOR_RDATA;
            end else if (!data_we_i) begin
                resp_rdata = mem_q[idx_t];
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[idx_t][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < RVALID_LAT; s++) begin
                rdata_q[s] <= 32'd0;
            end
        end else begin
            vld_q[0]   <= accept;
            err_q[0]   <= resp_err;
            rdata_q[0] <= resp_rdata;
            for (int s = 1; s < RVALID_LAT; s++) begin
                vld_q[s]   <= vld_q[s-1];
                err_q[s]   <= err_q[s-1];
                rdata_q[s] <= rdata_q[s-1];
            end
        end
    end

    assign data_rvalid_o = vld_q[RVALID_LAT-1];
    assign data_err_o    = err_q[RVALID_LAT-1];
    assign data_rdata_o  = rdata_q[RVALID_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// tb_data_mem_responder : scoreboard bench over three parameterisations.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cur    = 0;
    int   pops   = 0;
    int   lat [3] = '{1, 1, 4};

    data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    data_mem_responder #(.GNT_WAIT(3), .RVALID_LAT(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(4)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor for whichever instance is currently under test
    always @(negedge clk) begin
        if (rvalid[cur]) begin
            if (sb.size() == 0) begin
                check_eq("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rdata", rdata[cur], e.rdata);
                check_eq("err", {31'd0, err[cur]}, {31'd0, e.err});
                check_eq("latency", cyc, e.due);
                pops++;
            end
        end else begin
            check_eq("idle_out", rdata[cur] | {31'd0, err[cur]}, 32'd0);
        end
    end

    // Leaves req asserted on return so callers can chain back-to-back accesses
    task automatic access(input int s, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err,
                          output int waited);
        addr   = a;
        we     = w;
        be     = b;
        wdata  = d;
        req[s] = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!gnt[s] && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!gnt[s]) begin
            check_eq("gnt_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back(exp_t'{exp_rd, exp_err, cyc + lat[s]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int t;
        int p0;
        logic [15:0] m;

        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        we    = 1'b0;
        be    = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        req = 3'b111;
        @(negedge clk);
        check_eq("rst_gnt", {29'd0, gnt}, 32'd0);
        check_eq("rst_rvalid", {29'd0, rvalid}, 32'd0);
        check_eq("rst_rdata_c", rdata[2], 32'd0);
        check_eq("rst_err", {29'd0, err}, 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Instance A: basic, partial write, out of range
        cur = 0;
        access(0, 32'h10, 1'b1, 4'hF, 32'h1234_5678, 32'd0, 1'b0, w);
`ifndef DATA_MEM_STALL_EN
        check_eq("a_wr_wait", w, 0);
`endif
        access(0, 32'h10, 1'b0, 4'hF, 32'd0, 32'h1234_5678, 1'b0, w);
`ifndef DATA_MEM_STALL_EN
        check_eq("a_rd_wait", w, 0);
`endif
        access(0, 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0, w);
        access(0, 32'h13, 1'b0, 4'h0, 32'd0, 32'h12BB_56DD, 1'b0, w);
        access(0, 32'h0, 1'b1, 4'hF, 32'hCAFE_F00D, 32'd0, 1'b0, w);
        access(0, 32'h1000, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b1, w);
        access(0, 32'h1000, 1'b1, 4'hF, 32'h5555_5555, 32'd0, 1'b1, w);
        access(0, 32'h0, 1'b0, 4'hF, 32'd0, 32'hCAFE_F00D, 1'b0, w);
        idle(3);
        check_eq("a_drain", sb.size(), 0);

        // Instance B: GNT_WAIT=3
        cur = 1;
        access(1, 32'h20, 1'b1, 4'hF, 32'h0BAD_CAFE, 32'd0, 1'b0, w);
`ifndef DATA_MEM_STALL_EN
        check_eq("b_wr_wait", w, 3);
`endif
        idle(1);
        req[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle(1);
        access(1, 32'h20, 1'b0, 4'hF, 32'd0, 32'h0BAD_CAFE, 1'b0, w);
`ifndef DATA_MEM_STALL_EN
        check_eq("b_rd_wait", w, 3);
`endif
        idle(3);
        check_eq("b_drain", sb.size(), 0);

        // Instance C: RVALID_LAT=4, back-to-back, reset mid-flight
        cur = 2;
        for (int i = 0; i < 4; i++)
            access(2, 32'(i * 4), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i), 32'd0, 1'b0, w);
        idle(6);
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            access(2, 32'(i * 4), 1'b0, 4'hF, 32'd0, 32'hC0DE_0000 + 32'(i), 1'b0, w);
`ifndef DATA_MEM_STALL_EN
            check_eq("c_b2b_wait", w, 0);
`endif
        end
        req = '0;
        t = 0;
        while ((pops - p0) < 2 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("c_two_resp", pops - p0, 2);
        rst_n = 1'b0;
        req   = 3'b111;
        #2;
        check_eq("c_rst_gnt", {29'd0, gnt}, 32'd0);
        check_eq("c_rst_rvalid", {29'd0, rvalid}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        req   = '0;
        rst_n = 1'b1;
        access(2, 32'h0, 1'b0, 4'hF, 32'd0, 32'hC0DE_0000, 1'b0, w);
`ifndef DATA_MEM_STALL_EN
        check_eq("c_first_after_rst", w, 0);
`endif
        for (int i = 1; i < 4; i++)
            access(2, 32'(i * 4), 1'b0, 4'hF, 32'd0, 32'hC0DE_0000 + 32'(i), 1'b0, w);
        idle(8);
        check_eq("c_drain", sb.size(), 0);

`ifdef DATA_MEM_STALL_EN
        cur   = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        addr   = 32'h0;
        we     = 1'b0;
        req[0] = 1'b1;
        rst_n  = 1'b1;
        m      = 16'hACE1;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            check_eq("stall_gnt", {31'd0, gnt[0]}, {31'd0, m[0]});
            if (gnt[0]) sb.push_back(exp_t'{32'hCAFE_F00D, 1'b0, cyc + 1});
            @(posedge clk);
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
        #1;
        idle(4);
        check_eq("stall_drain", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
